// File: rtl/keypad_pkg.sv
// Shared encodings and default parameters for the matrix keypad scanner.
package keypad_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_REL_CHK   = 2'd3;

    localparam logic [1:0] CLS_NONE     = 2'd0;
    localparam logic [1:0] CLS_SINGLE   = 2'd1;
    localparam logic [1:0] CLS_MULTI    = 2'd2;

    localparam int DEF_ROWS     = 4;
    localparam int DEF_COLS     = 3;
    localparam int DEF_SCAN_DIV = 50000;
    localparam int DEF_DEBOUNCE = 4;

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM plus the valid/ready press-event holding register.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int CODE_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_vld,
    input  logic [1:0]        i_cls,
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_ready,
    output logic [CODE_W-1:0] o_code,
    output logic              o_valid,
    output logic              o_down,
    output logic              o_multi,
    output logic              o_overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic [1:0]        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CODE_W-1:0] r_cand, w_cand_nxt;
    logic              w_emit;
    logic              w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_emit      = 1'b0;
        if (i_frame_vld) begin
            case (r_state)
                ST_IDLE: if (i_cls == CLS_SINGLE) begin
                    w_cand_nxt = i_code;
                    w_cnt_nxt  = CNT_W'(1);
                    if (DEBOUNCE == 1) begin
                        w_state_nxt = ST_HELD;
                        w_emit      = 1'b1;
                    end else begin
                        w_state_nxt = ST_PRESS_CHK;
                    end
                end
                ST_PRESS_CHK: if (i_cls == CLS_SINGLE) begin
                    if (i_code == r_cand) begin
                        if (r_cnt == CNT_W'(DEBOUNCE - 1)) begin
                            w_state_nxt = ST_HELD;
                            w_emit      = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cand_nxt = i_code;
                        w_cnt_nxt  = CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
                // Held key masks everything, including a different key, until released.
                ST_HELD: if (i_cls == CLS_NONE) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = (DEBOUNCE == 1) ? ST_IDLE : ST_REL_CHK;
                end
                ST_REL_CHK: if (i_cls == CLS_NONE) begin
                    if (r_cnt == CNT_W'(DEBOUNCE - 1))
                        w_state_nxt = ST_IDLE;
                    else
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_state_nxt = ST_HELD;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_accept = o_valid & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cand    <= '0;
            o_code    <= '0;
            o_valid   <= 1'b0;
            o_multi   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cand    <= w_cand_nxt;
            o_overrun <= 1'b0;
            if (i_frame_vld)
                o_multi <= (i_cls == CLS_MULTI);
            // An accept in the same cycle frees the slot, so the new press replaces it.
            if (w_emit) begin
                if (!o_valid || w_accept) begin
                    o_valid <= 1'b1;
                    o_code  <= w_cand_nxt;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_down = (r_state == ST_HELD) || (r_state == ST_REL_CHK);

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobe matrix keypad scanner: divider, row sequencer, column synchroniser,
// frame bit-map and classifier feeding the debounce/handshake block.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int CODE_W   = $clog2(ROWS * COLS)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [COLS-1:0]   cols,
    output logic [ROWS-1:0]   rows,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_down,
    output logic              multi,
    output logic              overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int ROW_W = $clog2(ROWS);

    logic [DIV_W-1:0]           r_div;
    logic [ROW_W-1:0]           r_row;
    logic [ROWS-1:0]            r_rows;
    logic [COLS-1:0]            r_sync1, r_sync2;
    logic [ROWS-2:0][COLS-1:0]  r_map;
    logic                       r_cls_vld;
    logic [1:0]                 r_cls;
    logic [CODE_W-1:0]          r_cls_code;

    logic                       w_tick, w_last;
    logic [ROWS*COLS-1:0]       w_bits;
    logic [1:0]                 w_nset;
    logic [1:0]                 w_cls;
    logic [CODE_W-1:0]          w_code;

    assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_last = (r_row == ROW_W'(ROWS - 1));
    assign rows   = r_rows;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_div   <= '0;
            r_row   <= '0;
            r_rows  <= ~ROWS'(1);
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_map   <= '0;
        end else begin
            r_sync1 <= cols;
            r_sync2 <= r_sync1;
            r_div   <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                if (w_last) begin
                    r_row  <= '0;
                    r_rows <= ~ROWS'(1);
                end else begin
                    r_map[r_row] <= ~r_sync2;
                    r_row        <= r_row + ROW_W'(1);
                    r_rows       <= ~(ROWS'(1) << (r_row + ROW_W'(1)));
                end
            end
        end
    end

    // Last row is classified straight from the synchroniser, so the map never stores it.
    assign w_bits = {~r_sync2, r_map};

    always_comb begin
        w_nset = 2'd0;
        w_code = '0;
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (w_bits[i]) begin
                if (w_nset != 2'd2)
                    w_nset = w_nset + 2'd1;
                w_code = CODE_W'(i);
            end
        end
        w_cls = (w_nset == 2'd0) ? CLS_NONE :
                (w_nset == 2'd1) ? CLS_SINGLE : CLS_MULTI;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_cls_vld  <= 1'b0;
            r_cls      <= CLS_NONE;
            r_cls_code <= '0;
        end else begin
            r_cls_vld <= w_tick && w_last;
            if (w_tick && w_last) begin
                r_cls      <= w_cls;
                r_cls_code <= w_code;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CODE_W   (CODE_W)
    ) u_debounce (
        .i_clk       (CLOCK_50),
        .i_rst       (reset),
        .i_frame_vld (r_cls_vld),
        .i_cls       (r_cls),
        .i_code      (r_cls_code),
        .i_ready     (key_ready),
        .o_code      (key_code),
        .o_valid     (key_valid),
        .o_down      (key_down),
        .o_multi     (multi),
        .o_overrun   (overrun)
    );

endmodule
